// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble/flush controller with perf counters and memory timeout
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_raddr_i,
  input  logic [4:0]       id_rs2_raddr_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  input  logic             id_jtype_flag_i,
  input  logic             id_ex_mtype_i,
  input  logic             id_ex_mem_rw_i,
  input  logic [4:0]       id_ex_reg_waddr_i,
  input  logic             ex_btype_taken_i,
  input  logic             mem_busy_i,
  output logic             fc_stall_pc_o,
  output logic             fc_stall_if_id_o,
  output logic             fc_stall_id_ex_o,
  output logic             fc_stall_ex_mem_o,
  output logic             fc_bubble_id_ex_o,
  output logic             fc_flush_btype_flag_o,
  output logic             fc_flush_jtype_flag_o,
  output logic [CNT_W-1:0] fc_stall_cnt_o,
  output logic [CNT_W-1:0] fc_flush_cnt_o,
  output logic             fc_mem_timeout_o
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_flag_q, to_flag_d;
  logic             lu;
  logic             lu_eff;

  // Hazard decode and priority resolution; MEM_WAIT needs no special case because
  // a busy cycle stalls everything and the release cycle is evaluated like RUN.
  always_comb begin
    lu = id_ex_mtype_i && !id_ex_mem_rw_i && (id_ex_reg_waddr_i != 5'd0) &&
         ((id_rs1_re_i && (id_rs1_raddr_i == id_ex_reg_waddr_i)) ||
          (id_rs2_re_i && (id_rs2_raddr_i == id_ex_reg_waddr_i)));
    // ID/EX already carries the bubble during LU_STALL, so the hazard is gone.
    lu_eff = lu && (state_q != LU_STALL);

    fc_stall_pc_o         = 1'b0;
    fc_stall_if_id_o      = 1'b0;
    fc_stall_id_ex_o      = 1'b0;
    fc_stall_ex_mem_o     = 1'b0;
    fc_bubble_id_ex_o     = 1'b0;
    fc_flush_btype_flag_o = 1'b0;
    fc_flush_jtype_flag_o = 1'b0;
    state_d               = RUN;

    if (rst) begin
      state_d = RUN;
    end else if (mem_busy_i) begin
      fc_stall_pc_o     = 1'b1;
      fc_stall_if_id_o  = 1'b1;
      fc_stall_id_ex_o  = 1'b1;
      fc_stall_ex_mem_o = 1'b1;
      state_d           = MEM_WAIT;
    end else if (ex_btype_taken_i) begin
      fc_flush_btype_flag_o = 1'b1;
    end else if (lu_eff) begin
      fc_stall_pc_o     = 1'b1;
      fc_stall_if_id_o  = 1'b1;
      fc_bubble_id_ex_o = 1'b1;
      state_d           = LU_STALL;
    end else if (id_jtype_flag_i) begin
      fc_flush_jtype_flag_o = 1'b1;
    end
  end

  // Saturating performance counters and consecutive-busy timeout tracking.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fc_stall_pc_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((fc_flush_btype_flag_o || fc_flush_jtype_flag_o) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    to_cnt_d = '0;
    if (mem_busy_i) begin
      to_cnt_d = (to_cnt_q == TO_W'(MEM_TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
    end
    to_flag_d = to_flag_q || (to_cnt_d == TO_W'(MEM_TIMEOUT));
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      to_flag_q   <= to_flag_d;
    end
  end

  assign fc_stall_cnt_o   = stall_cnt_q;
  assign fc_flush_cnt_o   = flush_cnt_q;
  assign fc_mem_timeout_o = to_flag_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline flow controller for the 5-stage core. It watches the ID, ID/EX and EX/MEM stages and generates every stall, bubble and flush strobe consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It covers four cases: load-use hazards, taken branches resolved in EX, jumps resolved in ID, and multi-cycle data-memory waits. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
- `MEM_TIMEOUT`, default 64: number of consecutive `mem_busy_i` cycles after which `fc_mem_timeout_o` sets.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock, all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `id_rs1_raddr_i`  in  5  rs1 index of the instruction in ID.
- `id_rs2_raddr_i`  in  5  rs2 index of the instruction in ID.
- `id_rs1_re_i`  in  1  the ID instruction reads rs1.
- `id_rs2_re_i`  in  1  the ID instruction reads rs2.
- `id_jtype_flag_i`  in  1  the ID instruction is a jump (jal/jalr), target resolved in ID.
- `id_ex_mtype_i`  in  1  the ID/EX instruction is a memory access.
- `id_ex_mem_rw_i`  in  1  0 = load, 1 = store.
- `id_ex_reg_waddr_i`  in  5  destination register of the ID/EX instruction.
- `ex_btype_taken_i`  in  1  branch in EX is taken.
- `mem_busy_i`  in  1  data memory has not completed the access in MEM.
- `fc_stall_pc_o`  out  1  hold the PC.
- `fc_stall_if_id_o`  out  1  hold the IF/ID register.
- `fc_stall_id_ex_o`  out  1  hold the ID/EX register.
- `fc_stall_ex_mem_o`  out  1  hold the EX/MEM register.
- `fc_bubble_id_ex_o`  out  1  load NO_OP (all controls 0) into ID/EX.
- `fc_flush_btype_flag_o`  out  1  flush IF/ID and ID/EX.
- `fc_flush_jtype_flag_o`  out  1  flush IF/ID.
- `fc_stall_cnt_o`  out  CNT_W  cycles with `fc_stall_pc_o` = 1, saturating.
- `fc_flush_cnt_o`  out  CNT_W  cycles with either flush = 1, saturating.
- `fc_mem_timeout_o`  out  1  sticky timeout flag.

## Operation

**State register:** RUN, LU_STALL, MEM_WAIT. The control outputs are combinational, decoded from the current state and the current inputs.

**Load-use hazard (`lu`)** is true when all of the following hold:
- `id_ex_mtype_i` = 1 and `id_ex_mem_rw_i` = 0;
- `id_ex_reg_waddr_i` != 0;
- it equals `id_rs1_raddr_i` with `id_rs1_re_i` = 1, or equals `id_rs2_raddr_i` with `id_rs2_re_i` = 1.

**Priority in RUN** (highest first):
1. `mem_busy_i`: assert all four stalls; no bubble, no flush. Next state MEM_WAIT.
2. `ex_btype_taken_i`: assert `fc_flush_btype_flag_o`; stays RUN. The instruction in ID is squashed, so `lu` and `id_jtype_flag_i` are ignored.
3. `lu`: assert `fc_stall_pc_o`, `fc_stall_if_id_o` and `fc_bubble_id_ex_o`. Next state LU_STALL. A jump in ID waits; it is handled when re-evaluated after the stall.
4. `id_jtype_flag_i`: assert `fc_flush_jtype_flag_o`; stays RUN.
5. Otherwise: all outputs 0.

**LU_STALL** (exactly one cycle): `lu` is masked, because ID/EX now holds the bubble. Rules 1, 2 and 4 apply as in RUN. Next state is MEM_WAIT if `mem_busy_i`, else RUN.

**MEM_WAIT:**
- While `mem_busy_i` = 1: all four stalls asserted, branch/jump/`lu` suppressed.
- On the first cycle with `mem_busy_i` = 0: evaluate exactly as RUN, in the same cycle. The frozen branch or load-use is still present and is handled then. Next state follows the RUN rules.

**Timeout counter:**
- Counts consecutive `mem_busy_i` cycles and clears when `mem_busy_i` = 0.
- When the count reaches MEM_TIMEOUT, `fc_mem_timeout_o` sets and stays set until reset.
- Stalling continues regardless of the flag.

**Performance counters:** increment by 1 per qualifying cycle and saturate at all-ones.

## Timing

**Reset:**
- With `rst` = 1 at a rising edge: state becomes RUN; counters, timeout count and `fc_mem_timeout_o` become 0.
- While `rst` = 1, all stall/bubble/flush outputs are forced to 0.
- A reset during MEM_WAIT or LU_STALL abandons that state; there is no residual stall after reset.

**Latency:**
- Stall, bubble and flush outputs respond combinationally in the same cycle as their causing inputs.
- State, counters and the timeout flag update at the next rising edge.
- A load-use costs exactly 1 stall cycle.
- A taken branch produces a 1-cycle flush strobe.
- A jump produces a 1-cycle flush strobe per cycle it is seen in ID. Because IF/ID is flushed, it is seen once.
- A memory wait of N busy cycles stalls for exactly N cycles.

**Simultaneous events:**
- `mem_busy_i` together with a taken branch: stall only; the flush is issued on the release cycle.
- Branch together with `lu`: flush only, zero stall cycles.
- Counter increments in a cycle where `rst` = 1 are discarded.

## Test plan
- **Load-use:** ID/EX = load x5 (mtype=1, rw=0, waddr=5); ID reads rs1=5 with re=1 -> for 1 cycle `fc_stall_pc_o` = `fc_stall_if_id_o` = `fc_bubble_id_ex_o` = 1; next cycle all 0, even with inputs unchanged; `fc_stall_cnt_o` = 1.
- **No false hazard:** load to x0 with rs1 = 0, a store to x5, or a load x5 with `id_rs1_re_i` = 0 -> no stall.
- **Branch vs load-use:** `ex_btype_taken_i` = 1 in the same cycle as `lu` -> `fc_flush_btype_flag_o` = 1, no stall, `fc_flush_cnt_o` increments by 1.
- **Memory wait with pending branch:** `mem_busy_i` high 3 cycles with `ex_btype_taken_i` = 1 throughout -> 3 cycles of all four stalls with flush = 0, then a single flush on the release cycle.
- **Timeout:** MEM_TIMEOUT = 4 with `mem_busy_i` held 5 cycles -> `fc_mem_timeout_o` = 1 from the edge after the 4th busy cycle; it stays 1 after busy drops and clears only when `rst` = 1.
- **Reset mid-wait:** assert `rst` in MEM_WAIT -> outputs 0 immediately; after release with `mem_busy_i` = 0 the state is RUN and the counters are 0.
